seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Executes the existing logic and add/sub operations plus LEGv8 MUL, UMULH, UDIV and SDIV.
- Multiply and divide use an iterative radix-2 shift/add and shift/subtract engine.
- Valid/ready handshakes on both sides, so the EX stage can stall on long operations.
- One operation in flight at a time.

Parameters:
- WIDTH, 64, operand/result width in bits; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- a  in  WIDTH  operand a (dividend, multiplicand)
- b  in  WIDTH  operand b (divisor, multiplier)
- alu_ctl  in  4  operation select
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- alu_out  out  WIDTH  result
- zero  out  1  alu_out == 0
- negative  out  1  alu_out[WIDTH-1]
- carry  out  1  unsigned carry out (ADD/SUB only)
- overflow  out  1  signed overflow (ADD/SUB only)

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=1; out_valid=0; alu_out=0; all flags 0; counter=0. Reset asserted mid-operation abandons the operation; no result is produced.
- Encodings:
  - AND=0000, OR=0001, ADD=0010, SUB=0110, PASS=0111 (result = b)
  - MUL=1000 (low WIDTH bits of a*b), UMULH=1001 (high WIDTH bits of unsigned a*b)
  - UDIV=1010, SDIV=1011
  - Undefined codes: result 0, single-cycle.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch a, b, alu_ctl.
    - Single-cycle ops and divide-by-zero go to DONE.
    - MUL/UMULH/UDIV/SDIV go to BUSY with counter=WIDTH.
  - BUSY: in_ready=0. One iteration per cycle, counter decrements; at counter==1 the final iteration completes and the next state is DONE.
  - DONE: out_valid=1, outputs stable. When out_ready=1, go to IDLE.
  - in_ready is low in DONE, so there is no accept/deliver overlap.
- Latency, from the accept edge to out_valid high:
  - single-cycle ops: 1 cycle
  - multiply/divide: WIDTH+1 cycles
  - divide-by-zero: 1 cycle
- Add/sub arithmetic:
  - Computed at WIDTH+1 bits; SUB is a + ~b + 1.
  - carry = bit WIDTH.
  - overflow = operand signs equal (b inverted for SUB) and result sign differs.
- Flags:
  - zero and negative are valid for every op.
  - carry and overflow are 0 for all non-ADD/SUB ops.
- Multiply: shift-add over a 2*WIDTH product register; MUL and UMULH share the engine and select the half.
- UDIV: restoring division; quotient only.
- SDIV:
  - Divide magnitudes, then negate the quotient when the operand signs differ; truncates toward zero.
  - Most-negative / -1 returns the most-negative value.
- Divide by zero: UDIV/SDIV return 0, zero=1.
- Output back-pressure: out_ready low holds alu_out and all flags unchanged indefinitely.

Optional Feature:
- Macro SEQ_ALU_EARLY_TERM_EN.
- Defined:
  - MUL/UMULH leave BUSY as soon as the remaining unshifted multiplier bits are all zero.
  - Latency becomes (index of highest set bit of b)+2 cycles.
  - b==0 completes in 1 cycle.
  - Results identical to the non-early-termination build.
- Undefined: fixed WIDTH+1 latency for all multiply/divide ops. Divide is never early-terminated.

Decomposition:
- Package seq_alu_pkg holds:
  - ALU control encodings as localparams
  - state enum typedef {IDLE, BUSY, DONE}
  - helper function abs_val
- One sub-module, seq_alu_iter: the iterative multiply/divide datapath (product/remainder registers, counter, done pulse).
- The top level holds the FSM, single-cycle ops, flags and output registers.

Test Plan (WIDTH=64):
1. ADD a=7FFFFFFFFFFFFFFF, b=1 → out_valid after 1 cycle; alu_out=8000000000000000; overflow=1, negative=1, carry=0, zero=0.
2. SUB a=8000000000000000, b=1 → 7FFFFFFFFFFFFFFF, overflow=1, carry=1. Then AND FFFFFFFFFFFFFFFD & 3 → 1, carry=overflow=0.
3. MUL a=FFFFFFFFFFFFFFFF, b=FFFFFFFFFFFFFFFF:
   - MUL → 1, UMULH → FFFFFFFFFFFFFFFE.
   - out_valid exactly 65 cycles after accept.
   - in_ready=0 throughout.
4. SDIV a=-7, b=2 → FFFFFFFFFFFFFFFD (-3). SDIV 8000000000000000 / FFFFFFFFFFFFFFFF → 8000000000000000. UDIV 100 / 7 → 14 (0x0E).
5. UDIV b=0 → alu_out=0, zero=1, 1-cycle latency. Hold out_ready=0 for 10 cycles → outputs stable, in_ready=0. Then out_ready=1 → IDLE next cycle.
6. Start MUL, pull rst_n low at iteration 20 → out_valid=0 and in_ready=1 immediately. A subsequent ADD 2+3 returns 5. With SEQ_ALU_EARLY_TERM_EN defined, MUL b=3 completes in 3 cycles.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: ALU control encodings, FSM state type and the conditional
// negate helper shared by the sequential ALU and its iterative datapath.
package seq_alu_pkg;

    localparam logic [3:0] CTL_AND   = 4'b0000;
    localparam logic [3:0] CTL_OR    = 4'b0001;
    localparam logic [3:0] CTL_ADD   = 4'b0010;
    localparam logic [3:0] CTL_SUB   = 4'b0110;
    localparam logic [3:0] CTL_PASS  = 4'b0111;
    localparam logic [3:0] CTL_MUL   = 4'b1000;
    localparam logic [3:0] CTL_UMULH = 4'b1001;
    localparam logic [3:0] CTL_UDIV  = 4'b1010;
    localparam logic [3:0] CTL_SDIV  = 4'b1011;

    // Widest operand abs_val can handle; callers zero-extend in and truncate out.
    localparam int ABS_MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement negate when neg is set: magnitude of a signed value
    // given its sign bit, or re-signing a quotient.
    function automatic logic [ABS_MAX_W-1:0] abs_val(input logic [ABS_MAX_W-1:0] value,
                                                     input logic                 neg);
        return neg ? (~value + ABS_MAX_W'(1)) : value;
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: radix-2 shift/add multiply and restoring divide engine, one
// iteration per cycle. SEQ_ALU_EARLY_TERM_EN lets multiplies finish early.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_isDiv,
    input  logic [WIDTH-1:0] i_loInit,
    input  logic [WIDTH-1:0] i_operand,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hiNext,
    output logic [WIDTH-1:0] o_loNext
);

    // hi holds the product upper half or the partial remainder; lo holds the
    // multiplier/product lower half or the dividend/quotient.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_operand;
    logic             r_isDiv;
    logic [CNT_W-1:0] r_cnt;

    logic             w_busy;
    logic             w_last;
    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH:0]   w_remShift;
    logic [WIDTH:0]   w_remDiff;
    logic             w_remGe;
    logic [WIDTH-1:0] w_hiStep;
    logic [WIDTH-1:0] w_loStep;

    assign w_busy     = (r_cnt != '0);
    assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_operand} : '0);
    assign w_remShift = {r_hi, r_lo[WIDTH-1]};
    assign w_remDiff  = w_remShift - {1'b0, r_operand};
    assign w_remGe    = (w_remShift >= {1'b0, r_operand});

    always_comb begin
        w_hiStep = w_mulSum[WIDTH:1];
        w_loStep = {w_mulSum[0], r_lo[WIDTH-1:1]};
        if (r_isDiv) begin
            w_hiStep = w_remGe ? w_remDiff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
            w_loStep = {r_lo[WIDTH-2:0], w_remGe};
        end
    end

`ifdef SEQ_ALU_EARLY_TERM_EN
    // Shadow of the multiplier; once its unconsumed bits are zero the rest of
    // the iterations would only shift, so apply that shift in one step.
    logic [WIDTH-1:0]   r_mulRem;
    logic               w_early;
    logic [2*WIDTH-1:0] w_prodShift;

    assign w_early     = !r_isDiv && ((r_mulRem >> 1) == '0);
    assign w_prodShift = {w_hiStep, w_loStep} >> (r_cnt - CNT_W'(1));
    assign w_last      = w_busy && ((r_cnt == CNT_W'(1)) || w_early);
    assign o_hiNext    = w_early ? w_prodShift[2*WIDTH-1:WIDTH] : w_hiStep;
    assign o_loNext    = w_early ? w_prodShift[WIDTH-1:0] : w_loStep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mulRem <= '0;
        end else if (i_start) begin
            r_mulRem <= i_loInit;
        end else if (w_busy) begin
            r_mulRem <= r_mulRem >> 1;
        end
    end
`else
    assign w_last   = w_busy && (r_cnt == CNT_W'(1));
    assign o_hiNext = w_hiStep;
    assign o_loNext = w_loStep;
`endif

    assign o_done = w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_operand <= '0;
            r_isDiv   <= 1'b0;
            r_cnt     <= '0;
        end else if (i_start) begin
            r_hi      <= '0;
            r_lo      <= i_loInit;
            r_operand <= i_operand;
            r_isDiv   <= i_isDiv;
            r_cnt     <= CNT_W'(WIDTH);
        end else if (w_busy) begin
            r_hi      <= o_hiNext;
            r_lo      <= o_loNext;
            r_cnt     <= w_last ? '0 : (r_cnt - CNT_W'(1));
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes; logic/add/sub in one
// cycle, MUL/UMULH/UDIV/SDIV iteratively. Option macro: SEQ_ALU_EARLY_TERM_EN.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    state_t           r_state;
    state_t           w_nextState;
    logic [3:0]       r_ctl;
    logic             r_negQuot;
    logic [WIDTH-1:0] r_aluOut;
    logic             r_zero;
    logic             r_negative;
    logic             r_carry;
    logic             r_overflow;

    logic             w_accept;
    logic             w_isMul;
    logic             w_isDiv;
    logic             w_isSub;
    logic             w_bZero;
    logic             w_needIter;
    logic             w_iterStart;
    logic             w_iterDone;
    logic [WIDTH-1:0] w_aMag;
    logic [WIDTH-1:0] w_bMag;
    logic [WIDTH-1:0] w_iterLoInit;
    logic [WIDTH-1:0] w_iterOperand;
    logic [WIDTH-1:0] w_iterHi;
    logic [WIDTH-1:0] w_iterLo;
    logic [WIDTH-1:0] w_bEff;
    logic [WIDTH:0]   w_addSum;
    logic [WIDTH-1:0] w_singleRes;
    logic             w_singleCarry;
    logic             w_singleOvf;
    logic [WIDTH-1:0] w_iterRes;
    logic             w_loadRes;
    logic [WIDTH-1:0] w_resNext;
    logic             w_carryNext;
    logic             w_ovfNext;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_isMul  = (alu_ctl == CTL_MUL) || (alu_ctl == CTL_UMULH);
    assign w_isDiv  = (alu_ctl == CTL_UDIV) || (alu_ctl == CTL_SDIV);
    assign w_isSub  = (alu_ctl == CTL_SUB);
    assign w_bZero  = (b == '0);

    // Divide by zero (and, with early termination, multiply by zero) has a
    // known zero result and skips the engine entirely.
`ifdef SEQ_ALU_EARLY_TERM_EN
    assign w_needIter = (w_isMul || w_isDiv) && !w_bZero;
`else
    assign w_needIter = w_isMul || (w_isDiv && !w_bZero);
`endif
    assign w_iterStart = w_accept && w_needIter;

    assign w_aMag = (alu_ctl == CTL_SDIV) ? WIDTH'(abs_val(ABS_MAX_W'(a), a[WIDTH-1])) : a;
    assign w_bMag = (alu_ctl == CTL_SDIV) ? WIDTH'(abs_val(ABS_MAX_W'(b), b[WIDTH-1])) : b;
    assign w_iterLoInit  = w_isDiv ? w_aMag : b;
    assign w_iterOperand = w_isDiv ? w_bMag : a;

    seq_alu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_iterStart),
        .i_isDiv   (w_isDiv),
        .i_loInit  (w_iterLoInit),
        .i_operand (w_iterOperand),
        .o_done    (w_iterDone),
        .o_hiNext  (w_iterHi),
        .o_loNext  (w_iterLo)
    );

    assign w_bEff   = w_isSub ? ~b : b;
    assign w_addSum = {1'b0, a} + {1'b0, w_bEff} + {{WIDTH{1'b0}}, w_isSub};

    always_comb begin
        w_singleRes   = '0;
        w_singleCarry = 1'b0;
        w_singleOvf   = 1'b0;
        case (alu_ctl)
            CTL_AND:  w_singleRes = a & b;
            CTL_OR:   w_singleRes = a | b;
            CTL_ADD, CTL_SUB: begin
                w_singleRes   = w_addSum[WIDTH-1:0];
                w_singleCarry = w_addSum[WIDTH];
                w_singleOvf   = (a[WIDTH-1] == w_bEff[WIDTH-1]) &&
                                (w_addSum[WIDTH-1] != a[WIDTH-1]);
            end
            CTL_PASS: w_singleRes = b;
            default:  w_singleRes = '0;
        endcase
    end

    always_comb begin
        w_iterRes = '0;
        case (r_ctl)
            CTL_MUL, CTL_UDIV: w_iterRes = w_iterLo;
            CTL_UMULH:         w_iterRes = w_iterHi;
            CTL_SDIV:          w_iterRes = WIDTH'(abs_val(ABS_MAX_W'(w_iterLo), r_negQuot));
            default:           w_iterRes = '0;
        endcase
    end

    always_comb begin
        w_loadRes   = 1'b0;
        w_resNext   = w_singleRes;
        w_carryNext = w_singleCarry;
        w_ovfNext   = w_singleOvf;
        if (w_accept && !w_needIter) begin
            w_loadRes = 1'b1;
        end else if ((r_state == BUSY) && w_iterDone) begin
            w_loadRes   = 1'b1;
            w_resNext   = w_iterRes;
            w_carryNext = 1'b0;
            w_ovfNext   = 1'b0;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = w_needIter ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (w_iterDone) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl     <= '0;
            r_negQuot <= 1'b0;
        end else if (w_accept) begin
            r_ctl     <= alu_ctl;
            r_negQuot <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    // Results only change on a load, so back-pressure holds them as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aluOut   <= '0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_loadRes) begin
            r_aluOut   <= w_resNext;
            r_zero     <= (w_resNext == '0);
            r_negative <= w_resNext[WIDTH-1];
            r_carry    <= w_carryNext;
            r_overflow <= w_ovfNext;
        end
    end

    assign alu_out  = r_aluOut;
    assign zero     = r_zero;
    assign negative = r_negative;
    assign carry    = r_carry;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven and scoreboard checks of seq_alu at WIDTH=64,
// including back-pressure and reset during an operation.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W      = 64;
    localparam int BUDGET = 200;

    typedef struct {
        logic [3:0]   ctl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flags;
        int           hold;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_ctl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;
    logic [3:0]   dutFlags;

    int   nCompared = 0;
    int   nMismatch = 0;
    int   measLat;
    logic readyWhileBusy;
    vec_t vecs[$];
    vec_t scoreboard[$];
    logic [3:0] randOps[7] = '{CTL_ADD, CTL_SUB, CTL_MUL, CTL_UMULH, CTL_UDIV, CTL_SDIV, CTL_OR};

    assign dutFlags = {zero, negative, carry, overflow};

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_ctl   (alu_ctl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow)
    );

    task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [3:0] ctl, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] res, input logic [3:0] flags, input int hold);
        vec_t v;
        v.ctl = ctl; v.a = av; v.b = bv; v.res = res; v.flags = flags; v.hold = hold;
        vecs.push_back(v);
    endtask

    // Reference behaviour for the random vectors, written from the ISA meaning
    // of each operation.
    function automatic vec_t model(input logic [3:0] ctl, input logic [W-1:0] av, input logic [W-1:0] bv);
        vec_t         v;
        logic [2*W-1:0] prod;
        logic [W:0]   sum;
        logic         c;
        logic         o;
        v.ctl = ctl; v.a = av; v.b = bv; v.hold = 0; v.res = '0;
        c = 1'b0; o = 1'b0;
        prod = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
        case (ctl)
            CTL_AND:   v.res = av & bv;
            CTL_OR:    v.res = av | bv;
            CTL_ADD: begin
                sum = {1'b0, av} + {1'b0, bv};
                v.res = sum[W-1:0];
                c = sum[W];
                o = (av[W-1] == bv[W-1]) && (v.res[W-1] != av[W-1]);
            end
            CTL_SUB: begin
                sum = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
                v.res = sum[W-1:0];
                c = sum[W];
                o = (av[W-1] != bv[W-1]) && (v.res[W-1] != av[W-1]);
            end
            CTL_PASS:  v.res = bv;
            CTL_MUL:   v.res = prod[W-1:0];
            CTL_UMULH: v.res = prod[2*W-1:W];
            CTL_UDIV:  v.res = (bv == '0) ? '0 : av / bv;
            CTL_SDIV: begin
                if (bv == '0) v.res = '0;
                else if (av == {1'b1, {(W-1){1'b0}}} && bv == '1) v.res = av;
                else v.res = W'($signed(av) / $signed(bv));
            end
            default:   v.res = '0;
        endcase
        v.flags = {(v.res == '0), v.res[W-1], c, o};
        return v;
    endfunction

    function automatic int expLatency(input logic [3:0] ctl, input logic [W-1:0] bv);
        if (ctl == CTL_UDIV || ctl == CTL_SDIV) return (bv == '0) ? 1 : W + 1;
        if (ctl == CTL_MUL || ctl == CTL_UMULH) begin
`ifdef SEQ_ALU_EARLY_TERM_EN
            if (bv == '0) return 1;
            for (int i = W - 1; i >= 0; i--) if (bv[i]) return i + 2;
`endif
            return W + 1;
        end
        return 1;
    endfunction

    // Drive one request, push its expectation, and count cycles to out_valid.
    task automatic applyStimulus(input vec_t v);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        while (!in_ready && waitCnt < BUDGET) begin
            @(negedge clk);
            waitCnt++;
        end
        compare("in_ready_idle", W'(in_ready), W'(1));
        a = v.a; b = v.b; alu_ctl = v.ctl; in_valid = 1'b1;
        scoreboard.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        measLat = 1;
        readyWhileBusy = 1'b0;
        while (!out_valid && measLat < BUDGET) begin
            if (in_ready) readyWhileBusy = 1'b1;
            @(posedge clk); #1;
            measLat++;
        end
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        if (scoreboard.size() == 0) begin
            nCompared++;
            nMismatch++;
            $display("[TB] FAIL %s_scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        e = scoreboard.pop_front();
        compare({tag, "_latency"}, W'(measLat), W'(expLatency(e.ctl, e.b)));
        compare({tag, "_result"}, alu_out, e.res);
        compare({tag, "_flags_zncv"}, W'(dutFlags), W'(e.flags));
        compare({tag, "_in_ready_busy"}, W'(readyWhileBusy), W'(0));
        for (int i = 0; i < e.hold; i++) begin
            @(posedge clk); #1;
            compare({tag, "_hold_valid_ready"}, W'({out_valid, in_ready}), W'(2'b10));
            compare({tag, "_hold_result"}, alu_out, e.res);
            compare({tag, "_hold_flags"}, W'(dutFlags), W'(e.flags));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        compare({tag, "_release_ready_valid"}, W'({in_ready, out_valid}), W'(2'b10));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        logic sawValid;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; alu_ctl = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_in_ready", W'(in_ready), W'(1));
        compare("reset_out_valid", W'(out_valid), W'(0));
        compare("reset_alu_out", alu_out, '0);
        compare("reset_flags", W'(dutFlags), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        addVec(CTL_ADD,   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0101, 0);
        addVec(CTL_SUB,   64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 0);
        addVec(CTL_AND,   64'hFFFF_FFFF_FFFF_FFFD, 64'd3, 64'd1, 4'b0000, 0);
        addVec(CTL_MUL,   '1, '1, 64'd1, 4'b0000, 3);
        addVec(CTL_UMULH, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100, 0);
        addVec(CTL_SDIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 4'b0100, 0);
        addVec(CTL_SDIV,  64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 4'b0100, 0);
        addVec(CTL_UDIV,  64'd100, 64'd7, 64'd14, 4'b0000, 0);
        addVec(CTL_UDIV,  64'd5, 64'd0, 64'd0, 4'b1000, 10);
        addVec(CTL_SDIV,  64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0, 4'b1000, 0);
        addVec(CTL_OR,    64'hF0, 64'h0F, 64'hFF, 4'b0000, 0);
        addVec(CTL_PASS,  64'd123, 64'hDEAD, 64'hDEAD, 4'b0000, 0);
        addVec(4'b0011,   64'd5, 64'd5, 64'd0, 4'b1000, 0);
        addVec(CTL_SUB,   64'd5, 64'd5, 64'd0, 4'b1010, 0);
        addVec(CTL_MUL,   64'h10, 64'd3, 64'h30, 4'b0000, 0);
        addVec(CTL_MUL,   64'h1234, 64'd0, 64'd0, 4'b1000, 0);
        addVec(CTL_UMULH, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 4'b0000, 0);
        addVec(CTL_SDIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 4'b0100, 0);
        addVec(CTL_ADD,   '1, 64'd1, 64'd0, 4'b1010, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = {$urandom, $urandom};
            rb = (i % 2 == 1) ? {$urandom, $urandom} : W'($urandom_range(1, 1000));
            v = model(randOps[i % 7], ra, rb);
            applyStimulus(v);
            checkOutput($sformatf("rand%0d", i));
        end

        // Multiply abandoned by reset partway through its iterations.
        @(negedge clk);
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; alu_ctl = CTL_MUL; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        compare("midop_busy_ready_valid", W'({in_ready, out_valid}), W'(2'b00));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compare("midop_reset_ready_valid", W'({in_ready, out_valid}), W'(2'b10));
        compare("midop_reset_alu_out", alu_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) sawValid = 1'b1;
        end
        compare("midop_no_result", W'(sawValid), W'(0));
        applyStimulus(model(CTL_ADD, 64'd2, 64'd3));
        checkOutput("post_reset_add");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
